// File: rtl/vic1_microsequencer.sv
// Vic1 microsequencer: 512x36 microprogram store, MPC and MIR registers, the
// Mic-1 next-address rule, a microcode load port, start/halt lifecycle and a
// memory-stall hold that gates the issued microinstruction to a NOP.
module vic1_microsequencer #(
    parameter logic [8:0]  START_ADDR = 9'h000,
    parameter logic [8:0]  HALT_ADDR  = 9'h1FF,
    parameter logic [35:0] NOP_MIR    = 36'h00000000F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ucode_we,
    input  logic [8:0]  ucode_addr,
    input  logic [35:0] ucode_data,
    input  logic        start,
    input  logic        stall,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic [7:0]  mbr,
    output logic [35:0] mir,
    output logic [8:0]  mpc,
    output logic        running,
    output logic        halted,
    output logic [31:0] ucycle_count
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [8:0]   mpc_q, mpc_d;
    logic [35:0]  mir_q, mir_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [35:0]  store [512];
    logic         store_we;
    logic [8:0]   rd_addr;
    logic [35:0]  rd_data;
    logic [8:0]   next_mpc;

    // Microinstruction fields held in the MIR register.
    logic [8:0]   mir_next;
    logic         mir_jmpc, mir_jamn, mir_jamz;

    assign mir_next = mir_q[35:27];
    assign mir_jmpc = mir_q[26];
    assign mir_jamn = mir_q[25];
    assign mir_jamz = mir_q[24];

    // Mic-1 rule: the JAM bits OR into bit 8, MBR ORs into the low byte (no carry).
    assign next_mpc[8]   = mir_next[8] | (mir_jamz & alu_z) | (mir_jamn & alu_n);
    assign next_mpc[7:0] = mir_next[7:0] | (mir_jmpc ? mbr : 8'h00);

    assign rd_data = store[rd_addr];

    // Microprogram store write port; the store itself is never reset.
    always_ff @(posedge clock) begin
        if (store_we) begin
            store[ucode_addr] <= ucode_data;
        end
    end

    // Sequencer state, MPC, MIR and executed-microinstruction counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            mpc_q   <= 9'h000;
            mir_q   <= NOP_MIR;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            mir_q   <= mir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: loading, priming the MIR, stepping and halting.
    always_comb begin
        state_d  = state_q;
        mpc_d    = mpc_q;
        mir_d    = mir_q;
        cnt_d    = cnt_q;
        store_we = 1'b0;
        rd_addr  = next_mpc;
        case (state_q)
            S_LOAD, S_HALT: begin
                // A write in the start cycle lands before PRIME reads the store.
                store_we = ucode_we;
                if (start) begin
                    state_d = S_PRIME;
                    cnt_d   = 32'd0;
                end
            end
            S_PRIME: begin
                rd_addr = START_ADDR;
                mpc_d   = START_ADDR;
                mir_d   = rd_data;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    cnt_d = cnt_q + 32'd1;
                    if (next_mpc == HALT_ADDR) begin
                        state_d = S_HALT;
                        mpc_d   = HALT_ADDR;
                        mir_d   = NOP_MIR;
                    end else begin
                        mpc_d = next_mpc;
                        mir_d = rd_data;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // A stalled or non-running sequencer issues a NOP so the datapath does nothing.
    assign mir          = (state_q == S_RUN && !stall) ? mir_q : NOP_MIR;
    assign mpc          = mpc_q;
    assign running      = (state_q == S_RUN);
    assign halted       = (state_q == S_HALT);
    assign ucycle_count = cnt_q;

endmodule

// File: tb/tb_vic1_microsequencer.sv
// Bench for vic1_microsequencer: a cycle-level reference model of the Mic-1
// sequencing rules checked every cycle, plus directed scenarios with literal
// expectations (branching, dispatch, stall, load/start interplay, reset).
module tb_vic1_microsequencer;

    localparam logic [35:0] NOP = 36'h00000000F;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_HALT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ucode_we;
    logic [8:0]  ucode_addr;
    logic [35:0] ucode_data;
    logic        start, stall, alu_n, alu_z;
    logic [7:0]  mbr;
    logic [35:0] mir;
    logic [8:0]  mpc;
    logic        running, halted;
    logic [31:0] ucycle_count;

    int checks   = 0;
    int failures = 0;

    vic1_microsequencer dut (
        .clock(clock), .reset(reset), .ucode_we(ucode_we), .ucode_addr(ucode_addr),
        .ucode_data(ucode_data), .start(start), .stall(stall), .alu_n(alu_n),
        .alu_z(alu_z), .mbr(mbr), .mir(mir), .mpc(mpc), .running(running),
        .halted(halted), .ucycle_count(ucycle_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] mi(input logic [8:0] nx, input logic jmpc, input logic jamn,
                                       input logic jamz, input logic [8:0] c, input logic [3:0] b);
        return {nx, jmpc, jamn, jamz, 8'h00, c, 3'b000, b};
    endfunction

    // ---------------- reference model ----------------
    logic [35:0] m_store [512];
    int          m_mode;
    logic [8:0]  m_mpc;
    logic [31:0] m_cnt;
    logic [35:0] m_w;
    logic [8:0]  m_nxt;

    assign m_w   = m_store[m_mpc];
    assign m_nxt = {m_w[35] | (m_w[24] & alu_z) | (m_w[25] & alu_n),
                    m_w[34:27] | (m_w[26] ? mbr : 8'h00)};

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode <= M_IDLE;
            m_mpc  <= 9'h000;
            m_cnt  <= 32'd0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: begin
                    if (ucode_we) m_store[ucode_addr] <= ucode_data;
                    if (start) begin
                        m_mode <= M_PRIME;
                        m_cnt  <= 32'd0;
                    end
                end
                M_PRIME: begin
                    m_mpc  <= 9'h000;
                    m_mode <= M_RUN;
                end
                default: begin
                    if (!stall) begin
                        m_cnt <= m_cnt + 32'd1;
                        if (m_nxt == 9'h1FF) begin
                            m_mode <= M_HALT;
                            m_mpc  <= 9'h1FF;
                        end else begin
                            m_mpc <= m_nxt;
                        end
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("model_mir", {28'd0, mir},
            {28'd0, (m_mode == M_RUN && !stall) ? m_store[m_mpc] : NOP});
        chk("model_mpc", {55'd0, mpc}, {55'd0, m_mpc});
        chk("model_running", {63'd0, running}, {63'd0, m_mode == M_RUN});
        chk("model_halted", {63'd0, halted}, {63'd0, m_mode == M_HALT});
        chk("model_count", {32'd0, ucycle_count}, {32'd0, m_cnt});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [35:0] d);
        ucode_we = 1'b1; ucode_addr = a; ucode_data = d;
        tick();
        ucode_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 60 && !halted; i++) tick();
        chk(nm, {63'd0, halted}, 64'd1);
    endtask

    // Start, then step n cycles past PRIME and check the resulting MPC.
    task automatic run_to(input int n, input logic [8:0] exp_mpc, input string nm);
        pulse_start();
        repeat (n) tick();
        chk(nm, {55'd0, mpc}, {55'd0, exp_mpc});
        wait_halt({nm, "_halt"});
    endtask

    initial begin
        reset = 1'b0; ucode_we = 1'b0; ucode_addr = '0; ucode_data = '0;
        start = 1'b0; stall = 1'b0; alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00;
        #3;
        chk("reset_mir", {28'd0, mir}, {28'd0, NOP});
        chk("reset_mpc", {55'd0, mpc}, 64'd0);
        chk("reset_flags", {62'd0, running, halted}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Basic program: 0 -> 5 -> halt.
        wr(9'h000, mi(9'h005, 0, 0, 0, 9'h100, 4'h1));
        wr(9'h005, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        start = 1'b1;
        chk("start_cycle_nop", {28'd0, mir}, {28'd0, NOP});
        tick();
        start = 1'b0;
        chk("prime_nop", {28'd0, mir}, {28'd0, NOP});
        tick();
        chk("first_mpc", {55'd0, mpc}, 64'h000);
        chk("first_mir", {28'd0, mir}, {28'd0, mi(9'h005, 0, 0, 0, 9'h100, 4'h1)});
        tick();
        chk("second_mpc", {55'd0, mpc}, 64'h005);
        tick();
        chk("halted", {63'd0, halted}, 64'd1);
        chk("halt_mir", {28'd0, mir}, {28'd0, NOP});
        chk("halt_mpc", {55'd0, mpc}, 64'h1FF);
        chk("halt_count", {32'd0, ucycle_count}, 64'd2);

        // JAMZ / JAMN branches: 0 -> 0x10 -> (0x020 | 0x120).
        wr(9'h000, mi(9'h010, 0, 0, 0, 9'h000, 4'hF));
        wr(9'h010, mi(9'h020, 0, 0, 1, 9'h000, 4'hF));
        wr(9'h020, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        wr(9'h120, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        alu_z = 1'b1; run_to(3, 9'h120, "jamz_taken");
        alu_z = 1'b0; run_to(3, 9'h020, "jamz_not_taken");
        wr(9'h010, mi(9'h020, 0, 1, 0, 9'h000, 4'hF));
        alu_n = 1'b1; run_to(3, 9'h120, "jamn_taken");
        alu_n = 1'b0; run_to(3, 9'h020, "jamn_not_taken");
        alu_z = 1'b1; run_to(3, 9'h020, "jamn_ignores_z");
        alu_z = 1'b0;

        // JMPC dispatch.
        wr(9'h010, mi(9'h000, 1, 0, 0, 9'h000, 4'hF));
        wr(9'h060, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        mbr = 8'h60; run_to(3, 9'h060, "jmpc_60");
        wr(9'h010, mi(9'h100, 1, 0, 0, 9'h000, 4'hF));
        wr(9'h1A7, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        mbr = 8'hA7; run_to(3, 9'h1A7, "jmpc_1a7");
        mbr = 8'h00;

        // Stall for three cycles while mpc=0.
        wr(9'h010, mi(9'h011, 0, 0, 0, 9'h000, 4'hF));
        wr(9'h011, mi(9'h1FF, 0, 0, 0, 9'h000, 4'hF));
        pulse_start();
        tick();
        stall = 1'b1;
        #1;
        chk("stall_mir", {28'd0, mir}, {28'd0, NOP});
        repeat (3) tick();
        chk("stall_mpc", {55'd0, mpc}, 64'h000);
        chk("stall_count", {32'd0, ucycle_count}, 64'd0);
        stall = 1'b0;
        #1;
        chk("unstall_mir", {28'd0, mir}, {28'd0, mi(9'h010, 0, 0, 0, 9'h000, 4'hF)});
        tick();
        chk("unstall_mpc", {55'd0, mpc}, 64'h010);
        chk("unstall_count", {32'd0, ucycle_count}, 64'd1);
        wait_halt("stall_halt");
        chk("stall_final_count", {32'd0, ucycle_count}, 64'd3);

        // Write in the start cycle is seen by PRIME; RUN writes are ignored.
        wr(9'h050, mi(9'h1FF, 0, 0, 0, 9'h055, 4'h2));
        ucode_we = 1'b1; ucode_addr = 9'h000; ucode_data = mi(9'h050, 0, 0, 0, 9'h0AA, 4'h3);
        start = 1'b1;
        tick();
        ucode_we = 1'b0; start = 1'b0;
        tick();
        chk("same_cycle_write", {28'd0, mir}, {28'd0, mi(9'h050, 0, 0, 0, 9'h0AA, 4'h3)});
        ucode_we = 1'b1; ucode_addr = 9'h050; ucode_data = 36'hFFFFFFFFF;
        tick();
        ucode_we = 1'b0;
        chk("run_write_ignored", {28'd0, mir}, {28'd0, mi(9'h1FF, 0, 0, 0, 9'h055, 4'h2)});
        wait_halt("wr_halt");
        pulse_start();
        repeat (2) tick();
        chk("readback_mpc", {55'd0, mpc}, 64'h050);
        chk("readback_mir", {28'd0, mir}, {28'd0, mi(9'h1FF, 0, 0, 0, 9'h055, 4'h2)});
        wait_halt("readback_halt");

        // Async reset during RUN, then rerun retained microcode.
        wr(9'h000, mi(9'h010, 0, 0, 0, 9'h000, 4'hF));
        wr(9'h010, mi(9'h010, 0, 0, 0, 9'h000, 4'hF));
        pulse_start();
        repeat (3) tick();
        chk("pre_reset_count", {32'd0, ucycle_count}, 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_mir", {28'd0, mir}, {28'd0, NOP});
        chk("async_mpc", {55'd0, mpc}, 64'h000);
        chk("async_count", {32'd0, ucycle_count}, 64'd0);
        chk("async_running", {63'd0, running}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        pulse_start();
        tick();
        chk("retained_mir", {28'd0, mir}, {28'd0, mi(9'h010, 0, 0, 0, 9'h000, 4'hF)});
        tick();
        chk("retained_mpc", {55'd0, mpc}, 64'h010);
        tick();
        reset = 1'b0;
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vic1_microsequencer.md
Name: vic1_microsequencer

Overview:
- Upstream control stage of the Vic1 datapath: holds the 512-entry microprogram store, the MPC and the MIR, and drives the 36-bit microinstruction to the datapath each cycle.
- Computes the next MPC from NEXT_ADDRESS, the JAM bits, ALU N/Z and MBR (the Mic-1 rule).
- Provides a microcode load port, a start/halt lifecycle and a memory-stall hold.

Parameters:
START_ADDR  9'h000  first microinstruction address fetched on start
HALT_ADDR   9'h1FF  a computed next MPC equal to this enters HALT
NOP_MIR     36'h00000000F  microinstruction driven when idle or stalled (no C writes, no mem op, B_CONTROL=15 none)

Ports:
clock        input   1   system clock, rising edge
reset        input   1   asynchronous, active-low reset
ucode_we     input   1   microcode write strobe, honoured only in LOAD/HALT
ucode_addr   input   9   microcode write address
ucode_data   input   36  microcode write word
start        input   1   single-cycle pulse: begin execution at START_ADDR
stall        input   1   memory busy: hold sequencer this cycle
alu_n        input   1   ALU negative flag for the current microinstruction
alu_z        input   1   ALU zero flag for the current microinstruction
mbr          input   8   MBR byte for JMPC dispatch
mir          output  36  microinstruction to datapath {NEXT_ADDRESS[35:27], JMPC[26], JAMN[25], JAMZ[24], ALU[23:16], C[15:7], MEM[6:4], B[3:0]}
mpc          output  9   address of the microinstruction in the MIR register
running      output  1   high in RUN
halted       output  1   high in HALT
ucycle_count output  32  count of executed (non-stalled RUN) microinstructions

Behaviour:
- States: LOAD, PRIME, RUN, HALT.
- Reset (reset=0, async): state=LOAD, MPC=0, MIR reg=NOP_MIR, ucycle_count=0, running=0, halted=0. Store contents are not reset.
- LOAD/HALT:
  - ucode_we=1 writes store[ucode_addr] <= ucode_data at the clock edge.
  - start=1 goes to PRIME. A write in the same cycle completes before PRIME reads.
  - mir output = NOP_MIR.
- PRIME (exactly 1 cycle):
  - ucode_we is ignored; mir = NOP_MIR.
  - At the edge: MPC <= START_ADDR, MIR reg <= store[START_ADDR], state <= RUN.
- RUN:
  - mir = MIR reg when stall=0, else NOP_MIR (combinational gating).
  - next_mpc[8] = NEXT_ADDRESS[8] | (JAMZ & alu_z) | (JAMN & alu_n).
  - next_mpc[7:0] = NEXT_ADDRESS[7:0] | (JMPC ? mbr : 8'h00) (bitwise OR, no carry).
  - stall=0: at the edge MPC <= next_mpc, MIR reg <= store[next_mpc], ucycle_count += 1 (wraps at 2^32).
  - stall=1: MPC, MIR reg and ucycle_count hold; the flags are not sampled.
  - ucode_we and start are ignored.
- Halt: in RUN with stall=0 and next_mpc==HALT_ADDR:
  - the current microinstruction counts as executed;
  - state <= HALT, MPC <= HALT_ADDR, MIR reg <= NOP_MIR.
- HALT: halted=1. start re-enters PRIME, and execution restarts at START_ADDR. ucycle_count clears on each start.
- Latency: start in cycle t gives the first real mir in cycle t+2.
- Store: 512x36, single write port, synchronous read. Writes are legal only when no reads occur, so there are no read/write collisions.
- Reset mid-RUN returns to LOAD immediately. Microcode is retained, so a start without reload re-runs it.

Test Plan:
- Load store[0]=NEXT 9'h005 / C=9'h100 / B=4'h1, store[5]=NEXT 9'h1FF. Pulse start -> two cycles of NOP_MIR; mpc=0 with mir=store[0]; then mpc=5; then halted=1, mir=NOP_MIR, ucycle_count=2.
- JAMZ branch: store[0x010] has NEXT 9'h020 and JAMZ=1. With alu_z=1 -> next mpc=9'h120; with alu_z=0 -> next mpc=9'h020. Repeat for JAMN/alu_n.
- JMPC dispatch: NEXT 9'h000, JMPC=1, mbr=8'h60 -> mpc=9'h060. NEXT 9'h100, mbr=8'hA7 -> mpc=9'h1A7.
- Stall: hold stall=1 for 3 cycles mid-RUN -> mir=NOP_MIR, mpc and ucycle_count frozen. On release, the same microinstruction issues.
- Write/start interplay: write store[0]=X in the same cycle as start -> PRIME fetches X. A ucode_we during RUN leaves the store unchanged when read back after halt.
- Assert reset low while in RUN -> LOAD, mir=NOP_MIR, mpc=0, count=0 asynchronously. A subsequent start runs the retained microcode.
